md_unit: RTL
============

Name: md_unit

Overview:
- Multiply/divide unit for the EX stage of the pipelined MIPS CPU.
- Holds the architectural HI/LO registers and runs MULT/MULTU/DIV/DIVU as multi-cycle operations with a busy indication.
- Its HI and LO outputs feed the EX result-select multiplexer; busy/start feed the hazard unit, which stalls mult/div/mfhi/mflo/mthi/mtlo while the unit is occupied.

Parameters:
- DataBit, 32, operand and HI/LO width.
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (and MADD-family when enabled); legal range 1..15.
- DIV_CYCLES, 10, busy cycles for DIV/DIVU; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  EX-stage instruction is a mult/div-family op; qualified by op.
- op  input  4  0=none, 1=MULT, 2=MULTU, 3=DIV, 4=DIVU, 5=MTHI, 6=MTLO, 7=MADD, 8=MADDU, 9=MSUB, 10=MSUBU; others treated as none.
- req  input  1  exception/interrupt pending this cycle; suppresses any start.
- A  input  DataBit  rs operand (dividend / multiplicand / MTHI/MTLO data).
- B  input  DataBit  rt operand (divisor / multiplier).
- busy  output  1  operation in progress.
- HI  output  DataBit  architectural HI.
- LO  output  DataBit  architectural LO.

Behaviour:
- Reset: clk and rst_n are the only clock and reset; rst_n is asynchronous and active-low. Assertion forces busy=0, HI=0, LO=0, counter=0, shadow registers=0. This applies immediately, including mid-operation; the in-flight result is discarded.
- Accept condition: accept = start & ~req & ~busy & (op valid). start while busy is ignored and causes no state change.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, counter counts down from N to 1.
- Starting a mult/div: on the accepting edge E0, the result is computed combinationally from A/B into shadow registers hi_s/lo_s, counter=N, state goes to RUN. N is MULT_CYCLES or DIV_CYCLES by op.
- Completing a mult/div: busy is high for exactly N cycles after E0. At edge E_N, HI<=hi_s, LO<=lo_s, busy<=0, state goes to IDLE. HI/LO never change during RUN.
- MTHI/MTLO: single cycle. At the accepting edge, HI<=A (resp. LO<=A). busy stays 0.
- MULT: signed 64-bit product {HI,LO}. MULTU: unsigned.
- DIV/DIVU:
  - LO=quotient, HI=remainder.
  - Signed quotient truncates toward zero; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero (B=0): the operation still occupies DIV_CYCLES busy cycles; HI/LO are left unchanged at completion.
- req asserted while busy does not cancel the operation (the instruction has committed).
- Accept in the cycle busy falls: impossible, because busy is registered high at that edge. The next start is accepted from the cycle after completion.

Optional Feature:
- Macro: MD_MADD_EN.
- Defined: ops 7–10 are accepted with MULT_CYCLES latency.
  - MADD/MADDU: {HI,LO} += signed/unsigned A*B, modulo 2^64.
  - MSUB/MSUBU: {HI,LO} -= A*B.
  - The accumulate uses the HI/LO value at the accepting edge.
- Undefined: ops 7–10 are treated as none (no state change, busy stays 0) and no accumulate logic is synthesised.

Test Plan:
- Reset: hold rst_n=0 mid-DIV, release -> busy=0, HI=0, LO=0 immediately and after release.
- MULT: A=0xFFFFFFFE, B=3 -> busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV: A=-7 (0xFFFFFFF9), B=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU with B=0 after HI=0x11, LO=0x22 -> busy 10 cycles, HI/LO unchanged.
- Start while busy: issue DIV, then MTLO A=0x5 on cycle 3 -> ignored, LO ends with the quotient. start with req=1 -> no busy, HI/LO unchanged.
- MTHI A=0x1234 then MTLO A=0x5678 on consecutive cycles -> HI=0x1234, LO=0x5678, busy never asserted.
- MD_MADD_EN: HI=0, LO=0xFFFFFFFF, MADDU A=1, B=1 -> HI=1, LO=0. Without the macro, the same op leaves HI/LO unchanged.

Source files
------------

// File: rtl/md_unit.sv
// md_unit: multiply/divide unit for the EX stage; owns the architectural HI/LO registers.
// Latency: MULT/MULTU (and MADD family) occupy MULT_CYCLES busy cycles, DIV/DIVU occupy DIV_CYCLES; MTHI/MTLO complete at the accepting edge.
// Backpressure: busy=1 while running; start is ignored while busy or when req is high (no state change).
// Ports: clk, rst_n (async active-low); start/op/req select and qualify an operation; A/B are the rs/rt operands;
//        busy feeds the hazard unit; HI/LO feed the EX result multiplexer.
// Optional: define MD_MADD_EN to accept MADD/MADDU/MSUB/MSUBU (ops 7..10), accumulating into {HI,LO}.
module md_unit #(
  parameter int DataBit     = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [3:0]         op,
  input  logic               req,
  input  logic [DataBit-1:0] A,
  input  logic [DataBit-1:0] B,
  output logic               busy,
  output logic [DataBit-1:0] HI,
  output logic [DataBit-1:0] LO
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  localparam logic [3:0] LP_MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] LP_DIV_N  = 4'(DIV_CYCLES);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t               r_state;
  logic [3:0]           r_cnt;
  logic                 r_busy;
  logic                 r_wr;      // result is committed at completion (cleared for divide by zero)
  logic [DataBit-1:0]   r_hi;
  logic [DataBit-1:0]   r_lo;
  logic [DataBit-1:0]   r_hi_s;
  logic [DataBit-1:0]   r_lo_s;

  logic                 w_op_valid;
  logic                 w_is_mul;
  logic                 w_is_div;
  logic                 w_sgn;
  logic                 w_accept;

  // ---------------------------------------------------------------- decode
  always_comb begin
    w_op_valid = 1'b0;
    w_is_mul   = 1'b0;
    w_is_div   = 1'b0;
    w_sgn      = 1'b0;
    case (op)
      OP_MULT:  begin w_op_valid = 1'b1; w_is_mul = 1'b1; w_sgn = 1'b1; end
      OP_MULTU: begin w_op_valid = 1'b1; w_is_mul = 1'b1; end
      OP_DIV:   begin w_op_valid = 1'b1; w_is_div = 1'b1; w_sgn = 1'b1; end
      OP_DIVU:  begin w_op_valid = 1'b1; w_is_div = 1'b1; end
      OP_MTHI:  w_op_valid = 1'b1;
      OP_MTLO:  w_op_valid = 1'b1;
`ifdef MD_MADD_EN
      OP_MADD:  begin w_op_valid = 1'b1; w_is_mul = 1'b1; w_sgn = 1'b1; end
      OP_MADDU: begin w_op_valid = 1'b1; w_is_mul = 1'b1; end
      OP_MSUB:  begin w_op_valid = 1'b1; w_is_mul = 1'b1; w_sgn = 1'b1; end
      OP_MSUBU: begin w_op_valid = 1'b1; w_is_mul = 1'b1; end
`endif
      default:  w_op_valid = 1'b0;
    endcase
  end

  assign w_accept = start & ~req & ~r_busy & w_op_valid;

  // ---------------------------------------------------------------- multiply
  // Sign- or zero-extend to 2*DataBit; the low 2*DataBit bits of the product
  // are then the exact signed or unsigned result.
  logic [2*DataBit-1:0] w_ext_a;
  logic [2*DataBit-1:0] w_ext_b;
  logic [2*DataBit-1:0] w_prod;
  logic [2*DataBit-1:0] w_mul_res;

  assign w_ext_a = {{DataBit{w_sgn & A[DataBit-1]}}, A};
  assign w_ext_b = {{DataBit{w_sgn & B[DataBit-1]}}, B};
  assign w_prod  = w_ext_a * w_ext_b;

`ifdef MD_MADD_EN
  // Accumulate against HI/LO as they stand at the accepting edge.
  always_comb begin
    w_mul_res = w_prod;
    case (op)
      OP_MADD, OP_MADDU: w_mul_res = {r_hi, r_lo} + w_prod;
      OP_MSUB, OP_MSUBU: w_mul_res = {r_hi, r_lo} - w_prod;
      default:           w_mul_res = w_prod;
    endcase
  end
`else
  assign w_mul_res = w_prod;
`endif

  // ---------------------------------------------------------------- divide
  // Divide magnitudes, then fix signs: quotient truncates toward zero and the
  // remainder follows the dividend. The most-negative / -1 case falls out
  // naturally (magnitude 2^31 negates back to 0x80000000).
  logic               w_a_neg;
  logic               w_b_neg;
  logic               w_b_zero;
  logic [DataBit-1:0] w_a_mag;
  logic [DataBit-1:0] w_b_mag;
  logic [DataBit-1:0] w_b_safe;
  logic [DataBit-1:0] w_q_mag;
  logic [DataBit-1:0] w_r_mag;
  logic [DataBit-1:0] w_quot;
  logic [DataBit-1:0] w_rem;

  assign w_a_neg  = w_sgn & A[DataBit-1];
  assign w_b_neg  = w_sgn & B[DataBit-1];
  assign w_b_zero = (B == '0);
  assign w_a_mag  = w_a_neg ? -A : A;
  assign w_b_mag  = w_b_neg ? -B : B;
  // Keep the divider's operand defined on divide by zero; its result is never committed.
  assign w_b_safe = w_b_zero ? {{(DataBit-1){1'b0}}, 1'b1} : w_b_mag;
  assign w_q_mag  = w_a_mag / w_b_safe;
  assign w_r_mag  = w_a_mag % w_b_safe;
  assign w_quot   = (w_a_neg ^ w_b_neg) ? -w_q_mag : w_q_mag;
  assign w_rem    = w_a_neg ? -w_r_mag : w_r_mag;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_wr    <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_hi_s  <= '0;
      r_lo_s  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (op == OP_MTHI) begin
              r_hi <= A;
            end else if (op == OP_MTLO) begin
              r_lo <= A;
            end else if (w_is_mul) begin
              r_hi_s  <= w_mul_res[2*DataBit-1:DataBit];
              r_lo_s  <= w_mul_res[DataBit-1:0];
              r_wr    <= 1'b1;
              r_cnt   <= LP_MULT_N;
              r_busy  <= 1'b1;
              r_state <= S_RUN;
            end else if (w_is_div) begin
              r_hi_s  <= w_rem;
              r_lo_s  <= w_quot;
              r_wr    <= ~w_b_zero;
              r_cnt   <= LP_DIV_N;
              r_busy  <= 1'b1;
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          // req is deliberately ignored here: the instruction has committed.
          if (r_cnt == 4'd1) begin
            if (r_wr) begin
              r_hi <= r_hi_s;
              r_lo <= r_lo_s;
            end
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule
